// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter.
package regfile_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } state_e;

  localparam logic [1:0] RW_NOP   = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  // Encoding of last_grant / winner: which requester was served.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision; purely combinational.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt_a,
  output logic gnt_b
);

  // On a tie the requester not served last time wins.
  assign gnt_a = req_a & (~req_b | (last_grant == GNT_B));
  assign gnt_b = req_b & (~req_a | (last_grant == GNT_A));

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single register-file port and returns
// acks and read data to the granted requester.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              wr_a,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic [1:0]        rf_read_write,
  output logic [ADDR_W-1:0] rf_rw_reg,
  output logic [DATA_W-1:0] rf_in,
  output logic              rf_reg_on,
  input  logic [DATA_W-1:0] rf_out
);

  state_e              state_q, state_d;
  logic                winner_q, winner_d;
  logic                wr_q, wr_d;
  logic                last_grant_q, last_grant_d;
  logic                rst_done_q, rst_done_d;
  logic                ack_a_q, ack_a_d;
  logic                ack_b_q, ack_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
  logic [1:0]          rf_cmd_q, rf_cmd_d;
  logic [ADDR_W-1:0]   rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0]   rf_in_q, rf_in_d;
  logic                rf_on_q, rf_on_d;
  logic                gnt_a, gnt_b;

  rr_arb2 u_rr_arb2 (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant_q),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b)
  );

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    wr_d         = wr_q;
    last_grant_d = last_grant_q;
    // Blocks granting on the first edge after reset release.
    rst_done_d   = 1'b1;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    rf_cmd_d     = rf_cmd_q;
    rf_reg_d     = rf_reg_q;
    rf_in_d      = rf_in_q;
    rf_on_d      = rf_on_q;

    unique case (state_q)
      StIdle: begin
        if (rst_done_q && (gnt_a || gnt_b)) begin
          winner_d     = gnt_b ? GNT_B : GNT_A;
          wr_d         = gnt_b ? wr_b : wr_a;
          last_grant_d = gnt_b ? GNT_B : GNT_A;
          // rf_reg/rf_in double as the latched addr/wdata for the transaction.
          rf_reg_d     = gnt_b ? addr_b : addr_a;
          rf_in_d      = gnt_b ? wdata_b : wdata_a;
          rf_cmd_d     = (gnt_b ? wr_b : wr_a) ? RW_WRITE : RW_READ;
          rf_on_d      = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (wr_q) begin
          rf_cmd_d = RW_NOP;
          rf_on_d  = 1'b0;
          ack_a_d  = (winner_q == GNT_A);
          ack_b_d  = (winner_q == GNT_B);
          state_d  = StResp;
        end else begin
          state_d  = StCapt;
        end
      end
      StCapt: begin
        rf_cmd_d = RW_NOP;
        rf_on_d  = 1'b0;
        ack_a_d  = (winner_q == GNT_A);
        ack_b_d  = (winner_q == GNT_B);
        if (winner_q == GNT_B) begin
          rdata_b_d = rf_out;
        end else begin
          rdata_a_d = rf_out;
        end
        state_d  = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      winner_q     <= GNT_A;
      wr_q         <= 1'b0;
      last_grant_q <= GNT_B;
      rst_done_q   <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      rf_cmd_q     <= RW_NOP;
      rf_reg_q     <= '0;
      rf_in_q      <= '0;
      rf_on_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
      rst_done_q   <= rst_done_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      rf_cmd_q     <= rf_cmd_d;
      rf_reg_q     <= rf_reg_d;
      rf_in_q      <= rf_in_d;
      rf_on_q      <= rf_on_d;
    end
  end

  assign ack_a         = ack_a_q;
  assign ack_b         = ack_b_q;
  assign rdata_a       = rdata_a_q;
  assign rdata_b       = rdata_b_q;
  assign busy          = (state_q != StIdle);
  assign rf_read_write = rf_cmd_q;
  assign rf_rw_reg     = rf_reg_q;
  assign rf_in         = rf_in_q;
  assign rf_reg_on     = rf_on_q;

endmodule
